// File: rtl/char_buffer_writer.sv
// char_buffer_writer: turns a host byte stream into writes to the 80x25 text buffer, keeping a cursor and scrolling in place.
// Latency: a character write appears on wr_* the cycle after the byte is accepted; a scroll takes COLS*ROWS+1 cycles.
// Backpressure: in_ready is low (busy high) for the whole scroll; bytes transfer only when in_valid && in_ready.
//
// Ports:
//   clk, clr                 single clock, synchronous active-high reset
//   in_data/in_valid/in_ready  byte stream input with valid/ready handshake
//   wr_en/wr_addr/wr_data    buffer write port (row-major, addr = row*COLS+col)
//   rd_addr/rd_data          buffer read port used only while scrolling; rd_data lags rd_addr by one cycle
//   cursor_col/cursor_row    current cursor position
//   busy                     high while scrolling, always ~in_ready
// Build option: define VT52_ESC_EN to enable VT52 cursor escape sequences (ESC A/B/C/D/H).
module char_buffer_writer #(
  parameter int COLS   = 80,
  parameter int ROWS   = 25,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic [6:0]        cursor_col,
  output logic [4:0]        cursor_row,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_COPY  = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;
`ifdef VT52_ESC_EN
  localparam logic [1:0] ST_ESC   = 2'd3;
`endif

  localparam logic [6:0]        COL_MAX   = 7'(COLS - 1);
  localparam logic [4:0]        ROW_MAX   = 5'(ROWS - 1);
  // Number of copied cells; also the base address of the last row.
  localparam logic [ADDR_W-1:0] COPY_LAST = ADDR_W'(COLS * (ROWS - 1));
  localparam logic [ADDR_W-1:0] CLR_LAST  = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  logic [1:0]        state_q, state_d;
  logic [6:0]        col_q, col_d;
  logic [4:0]        row_q, row_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  // Marks a copy write cycle: the write data is rd_data straight from the buffer.
  logic              copy_wr_q, copy_wr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              start_scroll;
  logic [ADDR_W-1:0] cur_addr;

  assign cur_addr = ADDR_W'(row_q) * ADDR_W'(COLS) + ADDR_W'(col_q);

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    copy_wr_d    = 1'b0;
    rd_addr_d    = rd_addr_q;
    cnt_d        = cnt_q;
    start_scroll = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (in_data >= 8'h20 && in_data <= 8'h7E) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cur_addr;
            wr_data_d = in_data;
            if (col_q < COL_MAX) begin
              col_d = col_q + 7'd1;
            end else begin
              col_d = 7'd0;
              if (row_q < ROW_MAX) row_d = row_q + 5'd1;
              else                 start_scroll = 1'b1;
            end
          end else if (in_data == 8'h0D) begin
            col_d = 7'd0;
          end else if (in_data == 8'h0A) begin
            if (row_q < ROW_MAX) row_d = row_q + 5'd1;
            else                 start_scroll = 1'b1;
          end else if (in_data == 8'h08) begin
            if (col_q != 7'd0) col_d = col_q - 7'd1;
`ifdef VT52_ESC_EN
          end else if (in_data == 8'h1B) begin
            state_d = ST_ESC;
`endif
          end
        end
      end

      ST_COPY: begin
        // Keep the last copied byte so wr_data holds it once the copy stops.
        if (copy_wr_q) wr_data_d = rd_data;
        if (cnt_q == COPY_LAST) begin
          // Final copy write is on the bus now; queue the first clear write.
          state_d   = ST_CLEAR;
          cnt_d     = '0;
          wr_en_d   = 1'b1;
          wr_addr_d = COPY_LAST;
          wr_data_d = 8'h20;
        end else begin
          // Read of cell cnt+COLS is in flight; its write to cell cnt follows next cycle.
          wr_en_d   = 1'b1;
          copy_wr_d = 1'b1;
          wr_addr_d = cnt_q;
          cnt_d     = cnt_q + ONE;
          if (cnt_q != COPY_LAST - ONE) rd_addr_d = rd_addr_q + ONE;
        end
      end

      ST_CLEAR: begin
        if (cnt_q == CLR_LAST) begin
          state_d = ST_IDLE;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = COPY_LAST + cnt_q + ONE;
          wr_data_d = 8'h20;
          cnt_d     = cnt_q + ONE;
        end
      end

`ifdef VT52_ESC_EN
      ST_ESC: begin
        if (in_valid) begin
          state_d = ST_IDLE;
          case (in_data)
            8'h41: if (row_q != 5'd0) row_d = row_q - 5'd1;
            8'h42: if (row_q < ROW_MAX) row_d = row_q + 5'd1;
            8'h43: if (col_q < COL_MAX) col_d = col_q + 7'd1;
            8'h44: if (col_q != 7'd0) col_d = col_q - 7'd1;
            8'h48: begin
              col_d = 7'd0;
              row_d = 5'd0;
            end
            default: ;
          endcase
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase

    if (start_scroll) begin
      state_d   = ST_COPY;
      cnt_d     = '0;
      rd_addr_d = ADDR_W'(COLS);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= ST_IDLE;
      col_q     <= 7'd0;
      row_q     <= 5'd0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'h00;
      copy_wr_q <= 1'b0;
      rd_addr_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      copy_wr_q <= copy_wr_d;
      rd_addr_q <= rd_addr_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef VT52_ESC_EN
  assign in_ready = (state_q == ST_IDLE) || (state_q == ST_ESC);
`else
  assign in_ready = (state_q == ST_IDLE);
`endif
  assign busy       = ~in_ready;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  // Copy writes forward the registered buffer read directly.
  assign wr_data    = copy_wr_q ? rd_data : wr_data_q;
  assign rd_addr    = rd_addr_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;

endmodule

// File: tb/tb_char_buffer_writer.sv
module tb_char_buffer_writer;

  localparam int COLS  = 80;
  localparam int ROWS  = 25;
  localparam int CELLS = COLS * ROWS;

  logic        clk = 1'b0;
  logic        clr;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [7:0]  wr_data;
  logic [10:0] rd_addr;
  logic [7:0]  rd_data;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;

  // Screen buffer RAM seen by the DUT (registered read).
  logic [7:0] mem [0:2047];

  // Reference model: flat screen, cursor, escape flag.
  logic [7:0] m_scr [0:CELLS-1];
  int         m_col;
  int         m_row;
  bit         m_esc;

  always #5 clk = ~clk;

  char_buffer_writer dut (
    .clk        (clk),
    .clr        (clr),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  always @(posedge clk) begin
    if (wr_en === 1'b1) begin
      mem[wr_addr] <= wr_data;
      wr_cnt = wr_cnt + 1;
    end
    rd_data <= mem[rd_addr];
  end

  task automatic model_scroll();
    for (int r = 0; r < ROWS - 1; r++)
      for (int c = 0; c < COLS; c++)
        m_scr[r*COLS + c] = m_scr[(r+1)*COLS + c];
    for (int c = 0; c < COLS; c++) m_scr[(ROWS-1)*COLS + c] = 8'h20;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_esc) begin
      m_esc = 1'b0;
      case (b)
        8'h41: if (m_row > 0) m_row--;
        8'h42: if (m_row < ROWS - 1) m_row++;
        8'h43: if (m_col < COLS - 1) m_col++;
        8'h44: if (m_col > 0) m_col--;
        8'h48: begin m_col = 0; m_row = 0; end
        default: ;
      endcase
    end else if (b >= 8'h20 && b <= 8'h7E) begin
      m_scr[m_row*COLS + m_col] = b;
      if (m_col < COLS - 1) m_col++;
      else begin
        m_col = 0;
        if (m_row < ROWS - 1) m_row++;
        else model_scroll();
      end
    end else if (b == 8'h0D) begin
      m_col = 0;
    end else if (b == 8'h0A) begin
      if (m_row < ROWS - 1) m_row++;
      else model_scroll();
    end else if (b == 8'h08) begin
      if (m_col > 0) m_col--;
    end else if (b == 8'h1B) begin
`ifdef VT52_ESC_EN
      m_esc = 1'b1;
`endif
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_timeout in_ready=%b required 1", in_ready);
    end else begin
      in_data  = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      model_byte(b);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_timeout in_ready=%b required 1", in_ready);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    clr   = 1'b0;
    m_col = 0;
    m_row = 0;
    m_esc = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b0;
    m_col = 0; m_row = 0; m_esc = 1'b0;
    checks++;
    if (wr_en !== 1'b0 || wr_addr !== 11'd0 || wr_data !== 8'h00 || rd_addr !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs wr_en=%b wr_addr=%0d wr_data=%h rd_addr=%0d required 0/0/00/0",
               wr_en, wr_addr, wr_data, rd_addr);
    end
    checks++;
    if (cursor_col !== 7'd0 || cursor_row !== 5'd0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state col=%0d row=%0d in_ready=%b busy=%b required 0/0/1/0",
               cursor_col, cursor_row, in_ready, busy);
    end
  endtask

  task automatic test_hi();
    int w0;
    do_reset();
    w0 = wr_cnt;
    send_byte(8'h48);
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 11'd0 || wr_data !== 8'h48) begin
      errors++;
      $display("FAIL hi_first_write wr_en=%b addr=%0d data=%h required 1/0/48", wr_en, wr_addr, wr_data);
    end
    send_byte(8'h69);
    wait_idle();
    checks++;
    if (mem[0] !== 8'h48 || mem[1] !== 8'h69) begin
      errors++;
      $display("FAIL hi_mem mem0=%h mem1=%h required 48/69", mem[0], mem[1]);
    end
    checks++;
    if (cursor_col !== 7'd2 || cursor_row !== 5'd0) begin
      errors++;
      $display("FAIL hi_cursor col=%0d row=%0d required 2/0", cursor_col, cursor_row);
    end
    checks++;
    if (wr_cnt - w0 != 2) begin
      errors++;
      $display("FAIL hi_wr_pulses got=%0d required 2", wr_cnt - w0);
    end
  endtask

  task automatic test_control();
    int w0;
    do_reset();
    for (int i = 0; i < 5; i++) send_byte(8'h61 + 8'(i));
    wait_idle();
    checks++;
    if (int'(cursor_col) != 5) begin
      errors++;
      $display("FAIL ctl_setup col=%0d required 5", cursor_col);
    end
    w0 = wr_cnt;
    send_byte(8'h0D);
    checks++;
    if (cursor_col !== 7'd0) begin
      errors++;
      $display("FAIL ctl_cr col=%0d required 0", cursor_col);
    end
    send_byte(8'h08);
    wait_idle();
    checks++;
    if (cursor_col !== 7'd0 || cursor_row !== 5'd0) begin
      errors++;
      $display("FAIL ctl_bs col=%0d row=%0d required 0/0", cursor_col, cursor_row);
    end
    checks++;
    if (wr_cnt != w0) begin
      errors++;
      $display("FAIL ctl_no_write pulses=%0d required 0", wr_cnt - w0);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < COLS - 1; i++) send_byte(8'h30 + 8'(i % 10));
    send_byte(8'h5A);
    wait_idle();
    checks++;
    if (mem[79] !== 8'h5A) begin
      errors++;
      $display("FAIL wrap_mem mem79=%h required 5a", mem[79]);
    end
    checks++;
    if (cursor_col !== 7'd0 || cursor_row !== 5'd1) begin
      errors++;
      $display("FAIL wrap_cursor col=%0d row=%0d required 0/1", cursor_col, cursor_row);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    int first = -1;
    logic [7:0] b;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      int r = $urandom_range(0, 99);
      if (r < 72)      b = 8'($urandom_range(8'h20, 8'h7E));
      else if (r < 78) b = 8'h0D;
      else if (r < 84) b = 8'h0A;
      else if (r < 90) b = 8'h08;
      else if (r < 95) b = 8'h1B;
      else             b = 8'($urandom_range(0, 255));
      send_byte(b);
      checks++;
      if (int'(cursor_col) != m_col || int'(cursor_row) != m_row) begin
        errors++;
        $display("FAIL rand_cursor byte=%h col=%0d row=%0d required %0d/%0d",
                 b, cursor_col, cursor_row, m_col, m_row);
      end
    end
    wait_idle();
    for (int k = 0; k < CELLS; k++)
      if (mem[k] !== m_scr[k]) begin
        bad++;
        if (first < 0) first = k;
      end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rand_buffer mismatches=%0d first_addr=%0d got=%h required %h",
               bad, first, mem[first], m_scr[first]);
    end
  endtask

  task automatic test_scroll();
    int low = 0;
    int bsy_bad = 0;
    int bad = 0;
    int first = -1;
    int w0;
    do_reset();
    for (int k = 0; k < CELLS - 1; k++) send_byte(8'h20 + 8'(k % 95));
    wait_idle();
    checks++;
    if (cursor_col !== 7'd79 || cursor_row !== 5'd24) begin
      errors++;
      $display("FAIL scroll_setup col=%0d row=%0d required 79/24", cursor_col, cursor_row);
    end
    w0 = wr_cnt;
    send_byte(8'h0A);
    @(negedge clk);
    while (in_ready === 1'b0 && low < 5000) begin
      if (busy !== 1'b1) bsy_bad++;
      low++;
      @(negedge clk);
    end
    checks++;
    if (low != 2001) begin
      errors++;
      $display("FAIL scroll_busy_cycles got=%0d required 2001", low);
    end
    checks++;
    if (bsy_bad != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL scroll_busy_flag bad=%0d busy_after=%b required 0/0", bsy_bad, busy);
    end
    wait_idle();
    checks++;
    if (wr_cnt - w0 != 2000) begin
      errors++;
      $display("FAIL scroll_wr_pulses got=%0d required 2000", wr_cnt - w0);
    end
    for (int k = 0; k < CELLS; k++)
      if (mem[k] !== m_scr[k]) begin
        bad++;
        if (first < 0) first = k;
      end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL scroll_buffer mismatches=%0d first_addr=%0d got=%h required %h",
               bad, first, mem[first], m_scr[first]);
    end
    checks++;
    if (cursor_row !== 5'd24 || cursor_col !== 7'd79) begin
      errors++;
      $display("FAIL scroll_cursor col=%0d row=%0d required 79/24", cursor_col, cursor_row);
    end
    // Printable at the bottom-right corner: its write must land before the copy.
    send_byte(8'h51);
    wait_idle();
    checks++;
    if (mem[1919] !== 8'h51 || mem[1999] !== 8'h20 || mem[1920] !== 8'h20) begin
      errors++;
      $display("FAIL scroll_char_order mem1919=%h mem1920=%h mem1999=%h required 51/20/20",
               mem[1919], mem[1920], mem[1999]);
    end
    checks++;
    if (cursor_col !== 7'd0 || cursor_row !== 5'd24) begin
      errors++;
      $display("FAIL scroll_char_cursor col=%0d row=%0d required 0/24", cursor_col, cursor_row);
    end
  endtask

  task automatic test_reset_mid_scroll();
    do_reset();
    for (int i = 0; i < ROWS; i++) send_byte(8'h0A);
    repeat (500) @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    m_col = 0; m_row = 0; m_esc = 1'b0;
    checks++;
    if (wr_en !== 1'b0 || cursor_col !== 7'd0 || cursor_row !== 5'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_state wr_en=%b col=%0d row=%0d in_ready=%b required 0/0/0/1",
               wr_en, cursor_col, cursor_row, in_ready);
    end
    // An abandoned scroll leaves the buffer partly copied; adopt it as the model's starting point.
    for (int k = 0; k < CELLS; k++) m_scr[k] = mem[k];
    send_byte(8'h41);
    wait_idle();
    checks++;
    if (mem[0] !== 8'h41 || cursor_col !== 7'd1) begin
      errors++;
      $display("FAIL midreset_write mem0=%h col=%0d required 41/1", mem[0], cursor_col);
    end
  endtask

  task automatic test_esc();
    do_reset();
    for (int i = 0; i < 3; i++) send_byte(8'h0A);
    for (int i = 0; i < 10; i++) send_byte(8'h20);
    wait_idle();
    checks++;
    if (cursor_col !== 7'd10 || cursor_row !== 5'd3) begin
      errors++;
      $display("FAIL esc_setup col=%0d row=%0d required 10/3", cursor_col, cursor_row);
    end
`ifdef VT52_ESC_EN
    send_byte(8'h1B);
    send_byte(8'h41);
    checks++;
    if (cursor_row !== 5'd2 || cursor_col !== 7'd10) begin
      errors++;
      $display("FAIL esc_up col=%0d row=%0d required 10/2", cursor_col, cursor_row);
    end
    send_byte(8'h1B);
    send_byte(8'h43);
    checks++;
    if (cursor_col !== 7'd11 || cursor_row !== 5'd2) begin
      errors++;
      $display("FAIL esc_right col=%0d row=%0d required 11/2", cursor_col, cursor_row);
    end
    send_byte(8'h1B);
    send_byte(8'h48);
    wait_idle();
    checks++;
    if (cursor_col !== 7'd0 || cursor_row !== 5'd0) begin
      errors++;
      $display("FAIL esc_home col=%0d row=%0d required 0/0", cursor_col, cursor_row);
    end
`else
    send_byte(8'h1B);
    send_byte(8'h41);
    wait_idle();
    checks++;
    if (mem[250] !== 8'h41 || cursor_col !== 7'd11 || cursor_row !== 5'd3) begin
      errors++;
      $display("FAIL esc_ignored mem250=%h col=%0d row=%0d required 41/11/3",
               mem[250], cursor_col, cursor_row);
    end
`endif
  endtask

  initial begin
    clr      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    for (int k = 0; k < 2048; k++) begin
      logic [7:0] v = 8'($urandom_range(0, 255));
      mem[k] = v;
      if (k < CELLS) m_scr[k] = v;
    end
    test_reset();
    test_hi();
    test_control();
    test_wrap();
    test_random();
    test_scroll();
    test_reset_mid_scroll();
    test_esc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
